// File: rtl/stopwatch_bcd.sv
// ---------------------------------------------------------------------------
// stopwatch_bcd
//   MM:SS stopwatch. It produces four BCD digits that feed the 7-segment
//   decoders directly. The control inputs are single-cycle pulses from the
//   debounced board buttons.
//
// Parameters
//   TICK_DIV    clk cycles per one-second count increment (>= 2)
//
// Ports
//   clk         system clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   start_stop  pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN
//   clear       pulse: back to 00:00 / IDLE; overrides start_stop and lap
//   lap         pulse: toggles the display freeze (ignored in IDLE)
//   digit0      seconds units (0-9)
//   digit1      seconds tens  (0-5)
//   digit2      minutes units (0-9)
//   digit3      minutes tens  (0-5)
//   running     registered, 1 while in RUN
//   lap_active  1 while the display shows the frozen lap register
//   wrap        1-cycle pulse after the 59:59 -> 00:00 rollover
// ---------------------------------------------------------------------------
module stopwatch_bcd #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    cnt0, cnt1, cnt2, cnt3;
  logic [3:0]    lap0, lap1, lap2, lap3;

  // The tick is decided from the pre-edge state. A stop pulse on the tick
  // edge therefore still lets that second count.
  logic tick;
  assign tick = (state == RUN) && (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      running    <= 1'b0;
      presc      <= '0;
      cnt0       <= 4'd0;
      cnt1       <= 4'd0;
      cnt2       <= 4'd0;
      cnt3       <= 4'd0;
      lap0       <= 4'd0;
      lap1       <= 4'd0;
      lap2       <= 4'd0;
      lap3       <= 4'd0;
      lap_active <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        running    <= 1'b0;
        presc      <= '0;
        cnt0       <= 4'd0;
        cnt1       <= 4'd0;
        cnt2       <= 4'd0;
        cnt3       <= 4'd0;
        lap_active <= 1'b0;
      end else begin
        // Run/pause control
        if (start_stop) begin
          case (state)
            IDLE:    begin state <= RUN;   running <= 1'b1; end
            RUN:     begin state <= PAUSE; running <= 1'b0; end
            PAUSE:   begin state <= RUN;   running <= 1'b1; end
            default: begin state <= IDLE;  running <= 1'b0; end
          endcase
        end

        // Prescaler and BCD carry chain. In PAUSE the prescaler holds its
        // value, so a resume finishes the partial second.
        if (state == RUN) begin
          if (tick) begin
            presc <= '0;
            if (cnt0 == 4'd9) begin
              cnt0 <= 4'd0;
              if (cnt1 == 4'd5) begin
                cnt1 <= 4'd0;
                if (cnt2 == 4'd9) begin
                  cnt2 <= 4'd0;
                  if (cnt3 == 4'd5) begin
                    cnt3 <= 4'd0;
                    wrap <= 1'b1;
                  end else begin
                    cnt3 <= cnt3 + 4'd1;
                  end
                end else begin
                  cnt2 <= cnt2 + 4'd1;
                end
              end else begin
                cnt1 <= cnt1 + 4'd1;
              end
            end else begin
              cnt0 <= cnt0 + 4'd1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end

        // Lap freeze. The capture uses the pre-edge live count, so a tick
        // that lands on the same edge is not included in the frozen value.
        if (lap && (state != IDLE)) begin
          if (lap_active) begin
            lap_active <= 1'b0;
          end else begin
            lap0       <= cnt0;
            lap1       <= cnt1;
            lap2       <= cnt2;
            lap3       <= cnt3;
            lap_active <= 1'b1;
          end
        end
      end
    end
  end

  assign digit0 = lap_active ? lap0 : cnt0;
  assign digit1 = lap_active ? lap1 : cnt1;
  assign digit2 = lap_active ? lap2 : cnt2;
  assign digit3 = lap_active ? lap3 : cnt3;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_bcd
//   Directed bench for stopwatch_bcd with TICK_DIV=4, so one count happens
//   every 4 edges in RUN. The displayed digits are packed as 16'hMMSS for
//   compact expected values.
// ---------------------------------------------------------------------------
module tb_stopwatch_bcd;

  localparam int TICK_DIV = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_stop, clear, lap;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       running, lap_active, wrap;

  stopwatch_bcd #(.TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  logic [15:0] disp;
  assign disp = {digit3, digit2, digit1, digit0};

  int vectors     = 0;
  int miscompares = 0;

  // checker
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers (all called at posedge+1, away from the active edge)
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic c, input logic l);
    start_stop = s;
    clear      = c;
    lap        = l;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    #2;
    chk("por_disp",    disp, 16'h0000);
    chk("por_running", {15'd0, running}, 16'd0);
    chk("por_lap",     {15'd0, lap_active}, 16'd0);
    chk("por_wrap",    {15'd0, wrap}, 16'd0);
    @(negedge clk) rst_n = 1'b1;
    step(1);

    // 1: asynchronous reset in the middle of RUN at 00:07 with lap active
    pulse(1, 0, 0);
    step(28);
    chk("t1_pre_disp", disp, 16'h0007);
    pulse(0, 0, 1);
    chk("t1_pre_lap", {15'd0, lap_active}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_disp",    disp, 16'h0000);
    chk("t1_rst_running", {15'd0, running}, 16'd0);
    chk("t1_rst_lap",     {15'd0, lap_active}, 16'd0);
    chk("t1_rst_wrap",    {15'd0, wrap}, 16'd0);
    @(negedge clk) rst_n = 1'b1;
    step(5);
    chk("t1_post_disp", disp, 16'h0000);
    chk("t1_post_running", {15'd0, running}, 16'd0);

    // 2: count to 00:10 (seconds-units carry)
    pulse(1, 0, 0);
    chk("t2_start_running", {15'd0, running}, 16'd1);
    chk("t2_start_disp", disp, 16'h0000);
    step(3);
    chk("t2_before_tick", disp, 16'h0000);
    step(1);
    chk("t2_first_tick", disp, 16'h0001);
    step(35);
    chk("t2_0009", disp, 16'h0009);
    step(1);
    chk("t2_0010", disp, 16'h0010);
    chk("t2_running", {15'd0, running}, 16'd1);
    pulse(0, 1, 0);
    chk("t2_clear_disp", disp, 16'h0000);
    chk("t2_clear_running", {15'd0, running}, 16'd0);

    // 3: pause holds the prescaler; resume finishes the partial second.
    //    The stop edge is still a RUN edge, so the prescaler goes 2->3 on it.
    pulse(1, 0, 0);
    step(6);
    chk("t3_0001", disp, 16'h0001);
    pulse(1, 0, 0);
    chk("t3_pause_running", {15'd0, running}, 16'd0);
    step(100);
    chk("t3_paused_hold", disp, 16'h0001);
    pulse(1, 0, 0);
    chk("t3_resume_running", {15'd0, running}, 16'd1);
    chk("t3_resume_disp", disp, 16'h0001);
    step(1);
    chk("t3_0002", disp, 16'h0002);
    step(1);
    chk("t3_0002_hold", disp, 16'h0002);
    pulse(0, 1, 0);

    // 4: carries through every digit, then rollover at 3600 s = 14400 edges
    pulse(1, 0, 0);
    step(239);
    chk("t4_0059", disp, 16'h0059);
    step(1);
    chk("t4_0100", disp, 16'h0100);
    step(2160);
    chk("t4_1000", disp, 16'h1000);
    step(11999);
    chk("t4_5959", disp, 16'h5959);
    chk("t4_wrap_lo", {15'd0, wrap}, 16'd0);
    step(1);
    chk("t4_rollover", disp, 16'h0000);
    chk("t4_wrap_hi", {15'd0, wrap}, 16'd1);
    step(1);
    chk("t4_wrap_1cyc", {15'd0, wrap}, 16'd0);
    step(3);
    chk("t4_0001", disp, 16'h0001);
    chk("t4_running", {15'd0, running}, 16'd1);
    pulse(0, 1, 0);

    // 5: lap freeze while the live count keeps going
    pulse(1, 0, 0);
    step(12);
    chk("t5_0003", disp, 16'h0003);
    pulse(0, 0, 1);
    chk("t5_frozen_lap", {15'd0, lap_active}, 16'd1);
    step(8);
    chk("t5_frozen_disp", disp, 16'h0003);
    chk("t5_frozen_lap2", {15'd0, lap_active}, 16'd1);
    pulse(0, 0, 1);
    chk("t5_unfreeze_disp", disp, 16'h0005);
    chk("t5_unfreeze_lap", {15'd0, lap_active}, 16'd0);
    step(1);
    // The next edge is a tick edge; the capture must take the pre-tick 00:05.
    pulse(0, 0, 1);
    chk("t5_tick_capture", disp, 16'h0005);
    pulse(0, 0, 1);
    chk("t5_tick_live", disp, 16'h0006);
    pulse(0, 1, 0);

    // 6: clear wins over start_stop and lap; lap ignored in IDLE
    pulse(1, 0, 0);
    step(5);
    chk("t6_0001", disp, 16'h0001);
    pulse(1, 1, 0);
    chk("t6_clr_disp", disp, 16'h0000);
    chk("t6_clr_running", {15'd0, running}, 16'd0);
    pulse(0, 0, 1);
    chk("t6_idle_lap", {15'd0, lap_active}, 16'd0);
    step(8);
    chk("t6_idle_hold", disp, 16'h0000);
    chk("t6_idle_running", {15'd0, running}, 16'd0);
    pulse(1, 0, 0);
    step(4);
    pulse(0, 1, 1);
    chk("t6_clr_lap", {15'd0, lap_active}, 16'd0);
    chk("t6_clr_lap_disp", disp, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
